// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select and IF/ID latch; one-cycle fetch latency.
// Stall holds PC and IF/ID. Flush bubbles IF/ID. A redirect still moves the PC while stalled.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_id_inst_q, if_id_inst_d;
   logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] pc_plus4;

   always_comb begin
      pc_plus4         = pc_q + 32'd4;
      pc_d             = pc_plus4;
      if_id_inst_d     = imem_inst;
      if_id_pc_plus4_d = pc_plus4;
      if_id_valid_d    = 1'b1;
      fetch_count_d    = fetch_count_q + 32'd1;

      // Redirects outrank stall so a resolved branch is never lost behind a hazard.
      if (jump) begin
         pc_d = {jump_target[31:2], 2'b00};
      end else if (branch_taken) begin
         pc_d = {branch_target[31:2], 2'b00};
      end else if (stall) begin
         pc_d = pc_q;
      end

      if (flush) begin
         if_id_inst_d     = NOP_INST;
         if_id_pc_plus4_d = 32'd0;
         if_id_valid_d    = 1'b0;
         fetch_count_d    = fetch_count_q;
      end else if (stall) begin
         if_id_inst_d     = if_id_inst_q;
         if_id_pc_plus4_d = if_id_pc_plus4_q;
         if_id_valid_d    = if_id_valid_q;
         fetch_count_d    = fetch_count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q             <= RESET_PC;
         if_id_inst_q     <= NOP_INST;
         if_id_pc_plus4_q <= 32'd0;
         if_id_valid_q    <= 1'b0;
         fetch_count_q    <= 32'd0;
      end else begin
         pc_q             <= pc_d;
         if_id_inst_q     <= if_id_inst_d;
         if_id_pc_plus4_q <= if_id_pc_plus4_d;
         if_id_valid_q    <= if_id_valid_d;
         fetch_count_q    <= fetch_count_d;
      end
   end

   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign if_id_inst     = if_id_inst_q;
   assign if_id_pc_plus4 = if_id_pc_plus4_q;
   assign if_id_valid    = if_id_valid_q;
   assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized run against a cycle-level reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] imem_addr, imem_inst, pc, if_id_inst, if_id_pc_plus4, fetch_count;
   logic        if_id_valid;

   logic [31:0] mem [0:255];
   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
   logic        m_valid;

   always #5 clk = ~clk;

   assign imem_inst = mem[imem_addr[9:2]];

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .imem_addr(imem_addr), .imem_inst(imem_inst), .pc(pc),
      .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .fetch_count(fetch_count)
   );

   task automatic clear_inputs();
      rst = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
      branch_target = 0; jump_target = 0;
   endtask

   // One clock edge; the model advances from the inputs as they stand before the edge.
   task automatic tick();
      logic [31:0] n_pc, n_inst, n_pc4, n_cnt;
      logic        n_valid;
      if (rst) begin
         n_pc = 32'h0; n_inst = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0; n_cnt = 32'h0;
      end else begin
         n_inst = m_inst; n_pc4 = m_pc4; n_valid = m_valid; n_cnt = m_cnt;
         if (jump)              n_pc = jump_target & 32'hFFFF_FFFC;
         else if (branch_taken) n_pc = branch_target & 32'hFFFF_FFFC;
         else if (stall)        n_pc = m_pc;
         else                   n_pc = m_pc + 32'd4;
         if (flush) begin
            n_inst = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
         end else if (!stall) begin
            n_inst = mem[m_pc[9:2]]; n_pc4 = m_pc + 32'd4; n_valid = 1'b1; n_cnt = m_cnt + 32'd1;
         end
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_inst = n_inst; m_pc4 = n_pc4; m_valid = n_valid; m_cnt = n_cnt;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      tick(); tick();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_imem_addr got %h want 0", imem_addr); end
      n_cmp++; if (if_id_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", if_id_inst); end
      n_cmp++; if (if_id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4 got %h want 0", if_id_pc_plus4); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
      n_cmp++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL reset_count got %0d want 0", fetch_count); end
   endtask

   task automatic test_sequential();
      rst = 0;
      tick();
      n_cmp++; if (if_id_inst !== 32'h8C22_0000) begin n_err++; $display("FAIL seq1_inst got %h want 8c220000", if_id_inst); end
      n_cmp++; if (if_id_pc_plus4 !== 32'd4) begin n_err++; $display("FAIL seq1_pc4 got %h want 4", if_id_pc_plus4); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq1_valid got %b want 1", if_id_valid); end
      n_cmp++; if (pc !== 32'd4) begin n_err++; $display("FAIL seq1_pc got %h want 4", pc); end
      n_cmp++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL seq1_count got %0d want 1", fetch_count); end
      tick();
      n_cmp++; if (if_id_inst !== 32'h8C23_0001) begin n_err++; $display("FAIL seq2_inst got %h want 8c230001", if_id_inst); end
      n_cmp++; if (if_id_pc_plus4 !== 32'd8) begin n_err++; $display("FAIL seq2_pc4 got %h want 8", if_id_pc_plus4); end
      n_cmp++; if (pc !== 32'd8) begin n_err++; $display("FAIL seq2_pc got %h want 8", pc); end
      n_cmp++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL seq2_count got %0d want 2", fetch_count); end
   endtask

   task automatic test_stall();
      logic [31:0] cnt0;
      tick(); tick(); tick();
      n_cmp++; if (pc !== 32'd20) begin n_err++; $display("FAIL stall_setup_pc got %h want 14", pc); end
      cnt0 = fetch_count;
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (pc !== 32'd20) begin n_err++; $display("FAIL stall_pc got %h want 14", pc); end
         n_cmp++; if (if_id_inst !== 32'h2042_0005) begin n_err++; $display("FAIL stall_inst got %h want 20420005", if_id_inst); end
         n_cmp++; if (if_id_pc_plus4 !== 32'd20) begin n_err++; $display("FAIL stall_pc4 got %h want 14", if_id_pc_plus4); end
         n_cmp++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL stall_count got %0d want 5", fetch_count); end
      end
      n_cmp++; if (fetch_count !== cnt0) begin n_err++; $display("FAIL stall_count_hold got %0d want %0d", fetch_count, cnt0); end
      stall = 0;
      tick();
      n_cmp++; if (if_id_inst !== 32'h0043_3820) begin n_err++; $display("FAIL unstall_inst got %h want 00433820", if_id_inst); end
      n_cmp++; if (if_id_pc_plus4 !== 32'd24) begin n_err++; $display("FAIL unstall_pc4 got %h want 18", if_id_pc_plus4); end
   endtask

   task automatic test_branch_flush();
      jump = 1; jump_target = 32'd12; flush = 1;
      tick();
      clear_inputs();
      n_cmp++; if (pc !== 32'd12) begin n_err++; $display("FAIL br_setup_pc got %h want c", pc); end
      branch_taken = 1; branch_target = 32'h2E; flush = 1;
      tick();
      clear_inputs();
      n_cmp++; if (pc !== 32'h2C) begin n_err++; $display("FAIL br_pc got %h want 2c", pc); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL br_valid got %b want 0", if_id_valid); end
      n_cmp++; if (if_id_inst !== 32'h0) begin n_err++; $display("FAIL br_inst got %h want 0", if_id_inst); end
      tick();
      n_cmp++; if (if_id_inst !== 32'h0128_5022) begin n_err++; $display("FAIL br_next_inst got %h want 01285022", if_id_inst); end
      n_cmp++; if (if_id_pc_plus4 !== 32'h30) begin n_err++; $display("FAIL br_next_pc4 got %h want 30", if_id_pc_plus4); end
   endtask

   task automatic test_redirect_priority();
      logic [31:0] cnt0;
      cnt0 = m_cnt;
      jump = 1; jump_target = 32'h30; branch_taken = 1; branch_target = 32'h08; stall = 1; flush = 1;
      tick();
      clear_inputs();
      n_cmp++; if (pc !== 32'h30) begin n_err++; $display("FAIL prio_pc got %h want 30", pc); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL prio_valid got %b want 0", if_id_valid); end
      n_cmp++; if (fetch_count !== cnt0) begin n_err++; $display("FAIL prio_count got %0d want %0d", fetch_count, cnt0); end
   endtask

   task automatic test_wrap();
      jump = 1; jump_target = 32'hFFFF_FFFF;
      tick();
      clear_inputs();
      n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h want fffffffc", pc); end
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
      n_cmp++; if (imem_inst !== 32'hACE0_03FC) begin n_err++; $display("FAIL wrap_alias got %h want ace003fc", imem_inst); end
      tick();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc got %h want 0", pc); end
      n_cmp++; if (if_id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got %h want 0", if_id_pc_plus4); end
      n_cmp++; if (if_id_inst !== 32'hACE0_03FC) begin n_err++; $display("FAIL wrap_inst got %h want ace003fc", if_id_inst); end
      n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b want 1", if_id_valid); end
   endtask

   task automatic test_reset_mid();
      jump = 1; jump_target = 32'd40;
      tick();
      clear_inputs();
      n_cmp++; if (pc !== 32'd40) begin n_err++; $display("FAIL rmid_setup_pc got %h want 28", pc); end
      rst = 1; stall = 1; branch_taken = 1; branch_target = 32'h80;
      tick();
      clear_inputs();
      n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rmid_pc got %h want 0", pc); end
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", if_id_valid); end
      n_cmp++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL rmid_count got %0d want 0", fetch_count); end
      tick();
      n_cmp++; if (if_id_inst !== 32'h8C22_0000) begin n_err++; $display("FAIL rmid_first_inst got %h want 8c220000", if_id_inst); end
      n_cmp++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL rmid_first_count got %0d want 1", fetch_count); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 40) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         flush        = ($urandom_range(0, 4) == 0);
         branch_taken = ($urandom_range(0, 5) == 0);
         jump         = ($urandom_range(0, 7) == 0);
         branch_target = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, 10'($urandom)};
         jump_target   = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, 10'($urandom)};
         tick();
         n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
         n_cmp++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, imem_addr, m_pc); end
         n_cmp++; if (if_id_inst !== m_inst) begin n_err++; $display("FAIL rnd_inst cyc %0d got %h want %h", i, if_id_inst, m_inst); end
         n_cmp++; if (if_id_pc_plus4 !== m_pc4) begin n_err++; $display("FAIL rnd_pc4 cyc %0d got %h want %h", i, if_id_pc_plus4, m_pc4); end
         n_cmp++; if (if_id_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, if_id_valid, m_valid); end
         n_cmp++; if (fetch_count !== m_cnt) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, fetch_count, m_cnt); end
      end
      clear_inputs();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0]   = 32'h8C22_0000;
      mem[1]   = 32'h8C23_0001;
      mem[4]   = 32'h2042_0005;
      mem[5]   = 32'h0043_3820;
      mem[11]  = 32'h0128_5022;
      mem[255] = 32'hACE0_03FC;
      clear_inputs();
      test_reset();
      test_sequential();
      test_stall();
      test_branch_flush();
      test_redirect_priority();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
